mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
- REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
- REQ-002 SHALL have ports: rst  in  1  reset; asynchronous, active-low (0 = reset).
- REQ-003 SHALL have ports: ex_wd  in  5, ex_wreg  in  1, ex_wdata  in  32  destination register address, write enable and ALU result from the EX/MEM register.
- REQ-004 SHALL have ports: ex_whilo  in  1, ex_hi  in  32, ex_lo  in  32  HI/LO write enable and values.
- REQ-005 SHALL have ports: ex_aluop  in  8  operation code; ex_mem_addr  in  32  effective byte address; ex_reg2  in  32  store data.
- REQ-006 SHALL have ports: stall  in  6  pipeline stall vector; bit 4 = MEM/WB hold.
- REQ-007 SHALL have ports: mem_wd  out  5, mem_wreg  out  1, mem_wdata  out  32, mem_whilo  out  1, mem_hi  out  32, mem_lo  out  32  results to the MEM/WB register.
- REQ-008 SHALL have ports: stallreq  out  1  requests a pipeline freeze while a memory access is outstanding.
- REQ-009 SHALL have ports: bus_req  out  1, bus_we  out  1, bus_addr  out  32, bus_sel  out  4, bus_wdata  out  32  data bus request; bus_ack  in  1, bus_rdata  in  32  bus completion.
- REQ-010 SHALL have ports: misalign  out  1  misaligned-access flag.

Function
- REQ-011 SHALL treat EXE_LB/LBU/LH/LHU/LW_OP as loads, EXE_SB/SH/SW_OP as stores, using the shared defines; all other codes are non-memory.
- REQ-012 Non-memory op SHALL pass ex_* to mem_* combinationally with zero latency; stallreq=0, bus_req=0.
- REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
- REQ-014 IDLE + memory op SHALL drive stallreq=1 combinationally. On the next edge the block SHALL register bus_addr (word-aligned, [1:0]=00), bus_sel, bus_we and bus_wdata, set bus_req=1, and go to BUSY.
- REQ-015 BUSY SHALL hold all bus outputs stable and keep stallreq=1 until bus_ack=1.
- REQ-016 On the edge with bus_ack=1 in BUSY, the block SHALL:
  - capture the extracted load result (store: ex_wdata) into a result register;
  - drop bus_req;
  - go to DONE.
- REQ-017 DONE SHALL drive stallreq=0 and mem_wdata from the result register. It SHALL return to IDLE on the first edge with stall[4]=0 and otherwise hold.
- REQ-018 Byte lanes SHALL be big-endian: addr[1:0]=00 selects sel 1000 / bits [31:24], 01 selects 0100, 10 selects 0010, 11 selects 0001. Halfword: addr[1]=0 selects 1100, addr[1]=1 selects 0011. Word selects 1111.
- REQ-019 Stores SHALL replicate the byte/halfword across all lanes of bus_wdata. mem_wreg SHALL follow ex_wreg.
- REQ-020 LB/LH SHALL sign-extend the load result, LBU/LHU SHALL zero-extend, and LW SHALL pass the word through.
- REQ-021 bus_ack outside BUSY SHALL be ignored.

Reset
- REQ-022 rst=0 SHALL immediately force:
  - FSM to IDLE;
  - bus_req=0, bus_we=0, bus_sel=0, bus_addr=0, bus_wdata=0;
  - result register=0, misalign=0.
- REQ-023 An access aborted by reset SHALL be discarded; no completion SHALL follow.
- REQ-024 Registered outputs SHALL be 0 during reset; combinational outputs SHALL follow REQ-012.

Configuration
- REQ-025 Macro MEM_ALIGN_CHECK_EN SHALL control misalignment checking. A misaligned access is a halfword with addr[0]=1 or a word with addr[1:0]!=00.
- REQ-026 With MEM_ALIGN_CHECK_EN defined, a misaligned access SHALL:
  - skip the bus cycle;
  - go IDLE→DONE in one edge with misalign=1 and mem_wreg=0 while in DONE.
- REQ-027 Without MEM_ALIGN_CHECK_EN, misalign SHALL be tied 0 and low address bits SHALL be truncated (halfword addr[0], word addr[1:0] ignored).

Verification
- REQ-028 LB at addr 0x103, bus_rdata=0x123456F0, ack after 3 cycles:
  - bus_sel=0001;
  - stallreq high for 4 cycles;
  - mem_wdata=0xFFFFFFF0 in DONE.
- REQ-029 SH at addr 0x202, ex_reg2=0xAAAA1234:
  - bus_we=1, bus_sel=0011, bus_wdata=0x12341234;
  - mem_wreg follows ex_wreg.
- REQ-030 LW held in DONE by stall[4]=1 for 2 cycles: mem_wdata SHALL stay constant; IDLE on the first edge with stall[4]=0.
- REQ-031 ADDU op with ex_wdata=0x5 and ex_whilo=1: same-cycle pass-through, stallreq=0, bus_req=0.
- REQ-032 rst=0 asserted in BUSY: bus_req drops without waiting for a clock edge; a subsequent bus_ack SHALL be ignored.
- REQ-033 With MEM_ALIGN_CHECK_EN, LW at 0x101: no bus_req, misalign=1, mem_wreg=0. Without the macro, the same access reads from 0x100.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: passes ALU results through and runs loads/stores over a req/ack data bus.
// Define MEM_ALIGN_CHECK_EN to flag misaligned halfword/word accesses instead of truncating the address.

`ifndef EXE_LB_OP
`define EXE_LB_OP  8'b11100000
`endif
`ifndef EXE_LBU_OP
`define EXE_LBU_OP 8'b11100100
`endif
`ifndef EXE_LH_OP
`define EXE_LH_OP  8'b11100001
`endif
`ifndef EXE_LHU_OP
`define EXE_LHU_OP 8'b11100101
`endif
`ifndef EXE_LW_OP
`define EXE_LW_OP  8'b11100011
`endif
`ifndef EXE_SB_OP
`define EXE_SB_OP  8'b11101000
`endif
`ifndef EXE_SH_OP
`define EXE_SH_OP  8'b11101001
`endif
`ifndef EXE_SW_OP
`define EXE_SW_OP  8'b11101011
`endif

module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic        ex_whilo,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic [7:0]  ex_aluop,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_reg2,
    input  logic [5:0]  stall,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic        mem_whilo,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic        stallreq,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        misalign
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_next;

    logic        is_mem;
    logic        is_store;
    logic        bad_align;
    logic [1:0]  size_code;
    logic [1:0]  lane;
    logic [3:0]  sel;
    logic [31:0] wdata_rep;
    logic [7:0]  op_q;
    logic [1:0]  lane_q;
    logic [31:0] result_q;
    logic [31:0] load_val;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic        unused_stall;

    assign unused_stall = ^{stall[5], stall[3:0]};

    // size_code: 0 = byte, 1 = halfword, 2 = word
    always_comb begin
        is_mem    = 1'b1;
        is_store  = 1'b0;
        size_code = 2'd0;
        case (ex_aluop)
            `EXE_LB_OP, `EXE_LBU_OP: size_code = 2'd0;
            `EXE_LH_OP, `EXE_LHU_OP: size_code = 2'd1;
            `EXE_LW_OP:              size_code = 2'd2;
            `EXE_SB_OP: begin
                is_store  = 1'b1;
                size_code = 2'd0;
            end
            `EXE_SH_OP: begin
                is_store  = 1'b1;
                size_code = 2'd1;
            end
            `EXE_SW_OP: begin
                is_store  = 1'b1;
                size_code = 2'd2;
            end
            default: is_mem = 1'b0;
        endcase
    end

    // Big-endian lanes: byte offset 0 is bits [31:24]; low address bits below the access size are dropped.
    always_comb begin
        lane      = ex_mem_addr[1:0];
        sel       = 4'b1111;
        wdata_rep = ex_reg2;
        case (size_code)
            2'd0: begin
                sel       = 4'b1000 >> lane;
                wdata_rep = {4{ex_reg2[7:0]}};
            end
            2'd1: begin
                lane      = {ex_mem_addr[1], 1'b0};
                sel       = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
                wdata_rep = {2{ex_reg2[15:0]}};
            end
            default: lane = 2'b00;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign bad_align = ((size_code == 2'd1) && ex_mem_addr[0]) ||
                       ((size_code == 2'd2) && (ex_mem_addr[1:0] != 2'b00));
`else
    assign bad_align = 1'b0;
`endif

    always_comb begin
        case (lane_q)
            2'd1:    load_byte = bus_rdata[23:16];
            2'd2:    load_byte = bus_rdata[15:8];
            2'd3:    load_byte = bus_rdata[7:0];
            default: load_byte = bus_rdata[31:24];
        endcase
        load_half = lane_q[1] ? bus_rdata[15:0] : bus_rdata[31:16];
        case (op_q)
            `EXE_LB_OP:  load_val = {{24{load_byte[7]}}, load_byte};
            `EXE_LBU_OP: load_val = {24'h000000, load_byte};
            `EXE_LH_OP:  load_val = {{16{load_half[15]}}, load_half};
            `EXE_LHU_OP: load_val = {16'h0000, load_half};
            default:     load_val = bus_rdata;
        endcase
    end

    always_comb begin
        state_next = state;
        stallreq   = 1'b0;
        mem_wd     = ex_wd;
        mem_wreg   = ex_wreg;
        mem_wdata  = ex_wdata;
        mem_whilo  = ex_whilo;
        mem_hi     = ex_hi;
        mem_lo     = ex_lo;
        case (state)
            IDLE: begin
                if (is_mem) begin
                    stallreq   = 1'b1;
                    state_next = bad_align ? DONE : BUSY;
                end
            end
            BUSY: begin
                stallreq = 1'b1;
                if (bus_ack) state_next = DONE;
            end
            DONE: begin
                mem_wdata = result_q;
                if (misalign) mem_wreg = 1'b0;
                if (!stall[4]) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operation and lane are kept with the request so extraction does not depend on EX/MEM staying frozen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_sel   <= 4'h0;
            bus_wdata <= 32'h0;
            result_q  <= 32'h0;
            op_q      <= 8'h0;
            lane_q    <= 2'b00;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (is_mem && !bad_align) begin
                        bus_req   <= 1'b1;
                        bus_we    <= is_store;
                        bus_addr  <= {ex_mem_addr[31:2], 2'b00};
                        bus_sel   <= sel;
                        bus_wdata <= wdata_rep;
                        op_q      <= ex_aluop;
                        lane_q    <= lane;
                    end else if (is_mem) begin
                        result_q <= 32'h0;
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        result_q <= bus_we ? ex_wdata : load_val;
                        bus_req  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else if (state == IDLE && is_mem && bad_align) begin
            misalign_q <= 1'b1;
        end else if (state == DONE && !stall[4]) begin
            misalign_q <= 1'b0;
        end
    end

    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized loads/stores/ALU ops
// checked every cycle against a transaction-level model of the stage.

module tb_mem_stage;
    localparam logic [7:0] OP_LB   = 8'hE0;
    localparam logic [7:0] OP_LBU  = 8'hE4;
    localparam logic [7:0] OP_LH   = 8'hE1;
    localparam logic [7:0] OP_LHU  = 8'hE5;
    localparam logic [7:0] OP_LW   = 8'hE3;
    localparam logic [7:0] OP_SB   = 8'hE8;
    localparam logic [7:0] OP_SH   = 8'hE9;
    localparam logic [7:0] OP_SW   = 8'hEB;
    localparam logic [7:0] OP_ADDU = 8'h21;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk, rst;
    logic [4:0]  ex_wd;
    logic        ex_wreg, ex_whilo;
    logic [31:0] ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2;
    logic [7:0]  ex_aluop;
    logic [5:0]  stall;
    logic [4:0]  mem_wd;
    logic        mem_wreg, mem_whilo, stallreq, bus_req, bus_we, bus_ack, misalign;
    logic [31:0] mem_wdata, mem_hi, mem_lo, bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_sel;

    int n_checks = 0;
    int n_fail   = 0;

    bit          chk_en = 1'b0, chk_bus = 1'b0, chk_res = 1'b0, chk_pass = 1'b0;
    logic        e_stallreq, e_bus_req, e_bus_we, e_wreg, e_misal, e_whilo;
    logic [31:0] e_bus_addr, e_bus_wdata, e_wdata, e_hi, e_lo;
    logic [3:0]  e_bus_sel;
    logic [4:0]  e_wd;

    int          cap_stall;
    logic        cap_req_seen, cap_we, cap_wreg, cap_misal, cap_whilo, cap_wdata_changed;
    logic [3:0]  cap_sel;
    logic [31:0] cap_bwdata, cap_addr, cap_wdata, done_val;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
        .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
        .stall(stall),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .stallreq(stallreq),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .misalign(misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int op_size(input logic [7:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        if (op == OP_LW || op == OP_SW) return 4;
        return 0;
    endfunction

    function automatic bit op_is_store(input logic [7:0] op);
        return (op == OP_SB || op == OP_SH || op == OP_SW);
    endfunction

    function automatic bit op_is_signed(input logic [7:0] op);
        return (op == OP_LB || op == OP_LH);
    endfunction

    // Big-endian: byte at offset k occupies bits [31-8k -: 8]
    function automatic logic [31:0] model_load(input logic [7:0] op, input int lane, input logic [31:0] rdata);
        int s;
        logic [31:0] v, mask;
        s = op_size(op);
        v = rdata >> (8 * (4 - lane - s));
        mask = (s == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * s)) - 32'h1);
        v = v & mask;
        if (op_is_signed(op) && v[8 * s - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] model_sel(input int s, input int lane);
        int m;
        m = ((1 << s) - 1) << (4 - lane - s);
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_rep(input int s, input logic [31:0] v);
        if (s == 1) return (v & 32'hFF) * 32'h0101_0101;
        if (s == 2) return (v & 32'hFFFF) * 32'h0001_0001;
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("stallreq", 32'(stallreq), 32'(e_stallreq));
            checkOutput("bus_req", 32'(bus_req), 32'(e_bus_req));
            checkOutput("misalign", 32'(misalign), 32'(e_misal));
            if (chk_bus) begin
                checkOutput("bus_we", 32'(bus_we), 32'(e_bus_we));
                checkOutput("bus_addr", bus_addr, e_bus_addr);
                checkOutput("bus_sel", 32'(bus_sel), 32'(e_bus_sel));
                if (e_bus_we) checkOutput("bus_wdata", bus_wdata, e_bus_wdata);
            end
            if (chk_res) begin
                checkOutput("done_wd", 32'(mem_wd), 32'(e_wd));
                checkOutput("done_wreg", 32'(mem_wreg), 32'(e_wreg));
                if (!e_misal) checkOutput("done_wdata", mem_wdata, e_wdata);
            end
            if (chk_pass) begin
                checkOutput("pass_wd", 32'(mem_wd), 32'(e_wd));
                checkOutput("pass_wreg", 32'(mem_wreg), 32'(e_wreg));
                checkOutput("pass_wdata", mem_wdata, e_wdata);
                checkOutput("pass_whilo", 32'(mem_whilo), 32'(e_whilo));
                checkOutput("pass_hi", mem_hi, e_hi);
                checkOutput("pass_lo", mem_lo, e_lo);
            end
        end
    end

    task automatic sampleCycle();
        cap_stall += int'(stallreq);
        if (bus_req) begin
            cap_req_seen = 1'b1;
            cap_sel      = bus_sel;
            cap_we       = bus_we;
            cap_bwdata   = bus_wdata;
            cap_addr     = bus_addr;
        end
        cap_wdata = mem_wdata;
        cap_wreg  = mem_wreg;
        cap_misal = misalign;
        cap_whilo = mem_whilo;
    endtask

    task automatic applyAlu(input logic [7:0] op, input logic [31:0] wdata, input logic [4:0] wd,
                            input logic wreg, input logic whilo, input logic [31:0] hi, input logic [31:0] lo);
        cap_stall = 0;
        cap_req_seen = 1'b0;
        @(posedge clk); #1;
        ex_aluop = op; ex_wdata = wdata; ex_wd = wd; ex_wreg = wreg;
        ex_whilo = whilo; ex_hi = hi; ex_lo = lo;
        ex_mem_addr = $urandom; ex_reg2 = $urandom;
        stall = 6'($urandom); bus_ack = 1'($urandom); bus_rdata = $urandom;
        e_stallreq = 1'b0; e_bus_req = 1'b0; e_misal = 1'b0;
        e_wd = wd; e_wreg = wreg; e_wdata = wdata; e_whilo = whilo; e_hi = hi; e_lo = lo;
        chk_bus = 1'b0; chk_res = 1'b0; chk_pass = 1'b1; chk_en = 1'b1;
        @(negedge clk);
        sampleCycle();
    endtask

    // ack_delay: BUSY cycle (1-based) in which ack is raised; hold: DONE cycles with stall[4]=1
    task automatic applyStimulus(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                                 input logic [31:0] wdata, input logic [4:0] wd, input logic wreg,
                                 input logic [31:0] rdata, input int ack_delay, input int hold);
        int s, lane;
        bit mis;
        logic [31:0] res;
        s    = op_size(op);
        mis  = ALIGN_EN && ((addr % s) != 0);
        lane = int'(addr % 4) & ~(s - 1);
        res  = op_is_store(op) ? wdata : model_load(op, lane, rdata);
        cap_stall = 0;
        cap_req_seen = 1'b0;
        cap_wdata_changed = 1'b0;

        @(posedge clk); #1;
        ex_aluop = op; ex_mem_addr = addr; ex_reg2 = reg2; ex_wdata = wdata;
        ex_wd = wd; ex_wreg = wreg; ex_whilo = 1'b0; ex_hi = $urandom; ex_lo = $urandom;
        stall = 6'($urandom); bus_ack = 1'($urandom); bus_rdata = $urandom;
        e_stallreq = 1'b1; e_bus_req = 1'b0; e_misal = 1'b0;
        chk_bus = 1'b0; chk_res = 1'b0; chk_pass = 1'b0; chk_en = 1'b1;
        @(negedge clk);
        sampleCycle();

        if (!mis) begin
            for (int b = 1; b <= ack_delay; b++) begin
                @(posedge clk); #1;
                bus_ack   = (b == ack_delay);
                bus_rdata = (b == ack_delay) ? rdata : $urandom;
                stall     = 6'($urandom);
                e_stallreq = 1'b1; e_bus_req = 1'b1; e_misal = 1'b0;
                e_bus_we    = op_is_store(op);
                e_bus_addr  = addr & 32'hFFFF_FFFC;
                e_bus_sel   = model_sel(s, lane);
                e_bus_wdata = model_rep(s, reg2);
                chk_bus = 1'b1; chk_res = 1'b0;
                @(negedge clk);
                sampleCycle();
            end
        end

        for (int h = 0; h <= hold; h++) begin
            @(posedge clk); #1;
            bus_ack = 1'($urandom); bus_rdata = $urandom;
            stall = 6'($urandom);
            stall[4] = (h < hold);
            e_stallreq = 1'b0; e_bus_req = 1'b0; e_misal = mis;
            e_wd = wd; e_wreg = mis ? 1'b0 : wreg; e_wdata = res;
            chk_bus = 1'b0; chk_res = 1'b1;
            @(negedge clk);
            sampleCycle();
            if (h == 0) done_val = mem_wdata;
            else if (mem_wdata !== done_val) cap_wdata_changed = 1'b1;
        end
    endtask

    logic [7:0] mem_ops [8] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};

    initial begin
        logic [7:0] op8;
        rst = 1'b0;
        ex_aluop = OP_ADDU; ex_wd = 5'd1; ex_wreg = 1'b1; ex_wdata = 32'h0;
        ex_whilo = 1'b0; ex_hi = 32'h0; ex_lo = 32'h0; ex_mem_addr = 32'h0; ex_reg2 = 32'h0;
        stall = 6'h0; bus_ack = 1'b0; bus_rdata = 32'h0;

        #2;
        checkOutput("reset_bus_req", 32'(bus_req), 32'h0);
        checkOutput("reset_bus_we", 32'(bus_we), 32'h0);
        checkOutput("reset_bus_sel", 32'(bus_sel), 32'h0);
        checkOutput("reset_bus_addr", bus_addr, 32'h0);
        checkOutput("reset_bus_wdata", bus_wdata, 32'h0);
        checkOutput("reset_misalign", 32'(misalign), 32'h0);
        checkOutput("reset_stallreq", 32'(stallreq), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        applyAlu(OP_ADDU, 32'h5, 5'd7, 1'b1, 1'b1, 32'hDEAD_0001, 32'hBEEF_0002);
        checkOutput("addu_wdata", cap_wdata, 32'h5);
        checkOutput("addu_stallreq", 32'(cap_stall), 32'h0);
        checkOutput("addu_bus_req", 32'(cap_req_seen), 32'h0);
        checkOutput("addu_whilo", 32'(cap_whilo), 32'h1);

        applyStimulus(OP_LB, 32'h103, 32'h0, 32'h0, 5'd4, 1'b1, 32'h1234_56F0, 3, 0);
        checkOutput("lb_sel", 32'(cap_sel), 32'h1);
        checkOutput("lb_stall_cycles", 32'(cap_stall), 32'd4);
        checkOutput("lb_wdata", cap_wdata, 32'hFFFF_FFF0);
        checkOutput("lb_bus_addr", cap_addr, 32'h100);

        applyStimulus(OP_SH, 32'h202, 32'hAAAA_1234, 32'h0000_0202, 5'd5, 1'b1, 32'h0, 2, 0);
        checkOutput("sh_we", 32'(cap_we), 32'h1);
        checkOutput("sh_sel", 32'(cap_sel), 32'h3);
        checkOutput("sh_bus_wdata", cap_bwdata, 32'h1234_1234);
        checkOutput("sh_wreg1", 32'(cap_wreg), 32'h1);
        applyStimulus(OP_SH, 32'h202, 32'hAAAA_1234, 32'h0000_0202, 5'd5, 1'b0, 32'h0, 1, 0);
        checkOutput("sh_wreg0", 32'(cap_wreg), 32'h0);

        applyStimulus(OP_LW, 32'h300, 32'h0, 32'h0, 5'd6, 1'b1, 32'hCAFE_F00D, 1, 2);
        checkOutput("lw_hold_stable", 32'(cap_wdata_changed), 32'h0);
        checkOutput("lw_hold_wdata", cap_wdata, 32'hCAFE_F00D);
        applyAlu(OP_ADDU, 32'h0BAD_CAFE, 5'd8, 1'b1, 1'b0, 32'h0, 32'h0);
        checkOutput("lw_after_idle", cap_wdata, 32'h0BAD_CAFE);

        applyStimulus(OP_LW, 32'h101, 32'h0, 32'h0, 5'd9, 1'b1, 32'h1122_3344, 2, 0);
`ifdef MEM_ALIGN_CHECK_EN
        checkOutput("mis_no_bus", 32'(cap_req_seen), 32'h0);
        checkOutput("mis_flag", 32'(cap_misal), 32'h1);
        checkOutput("mis_wreg", 32'(cap_wreg), 32'h0);
`else
        checkOutput("trunc_addr", cap_addr, 32'h100);
        checkOutput("trunc_sel", 32'(cap_sel), 32'hF);
        checkOutput("trunc_wdata", cap_wdata, 32'h1122_3344);
`endif

        // Reset while a load is outstanding
        @(posedge clk); #1;
        chk_en = 1'b0;
        ex_aluop = OP_LW; ex_mem_addr = 32'h40; bus_ack = 1'b0; stall = 6'h0;
        @(posedge clk); #1;
        checkOutput("abort_busreq_before", 32'(bus_req), 32'h1);
        #2 rst = 1'b0;
        #1;
        checkOutput("abort_busreq_async", 32'(bus_req), 32'h0);
        checkOutput("abort_bus_addr", bus_addr, 32'h0);
        checkOutput("abort_bus_sel", 32'(bus_sel), 32'h0);
        ex_aluop = OP_ADDU; ex_wdata = 32'h77;
        @(posedge clk); #1;
        rst = 1'b1; bus_ack = 1'b1;
        @(negedge clk);
        checkOutput("abort_ack_stallreq", 32'(stallreq), 32'h0);
        checkOutput("abort_ack_busreq", 32'(bus_req), 32'h0);
        checkOutput("abort_ack_wdata", mem_wdata, 32'h77);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        checkOutput("abort_after_stallreq", 32'(stallreq), 32'h0);
        checkOutput("abort_after_wdata", mem_wdata, 32'h77);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) < 3) begin
                op8 = 8'($urandom);
                if (op_size(op8) != 0) op8 = OP_ADDU;
                applyAlu(op8, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
            end else begin
                op8 = mem_ops[$urandom_range(0, 7)];
                applyStimulus(op8, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom),
                              $urandom, int'($urandom_range(1, 4)), int'($urandom_range(0, 2)));
            end
        end

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
